fsm_countdown: RTL
==================

Name: fsm_countdown

Overview:
Moore state machine that counts the LED value down from START_VALUE to zero after a debounced press of the go button, then pulses done_sig and returns to idle. It is the down-counting counterpart of the board's up-counting LED FSM and targets the same iCEstick 12 MHz clock and 4-LED bank. It runs entirely in the clk domain and paces itself with a single-cycle tick enable, not a derived clock.

Parameters:
TICK_COUNT, 1500000, clk cycles per count step (8 Hz at 12 MHz); must be >= 2
DEBOUNCE_COUNT, 120000, consecutive stable clk cycles needed to accept a button level change (10 ms)
START_VALUE, 4'hF, value loaded into led when a count starts

Ports:
clk  input  1  system clock, 12 MHz
rst  input  1  asynchronous, active-high reset
go_btn  input  1  raw active-low push button, asynchronous to clk
led  output  4  current count value
done_sig  output  1  high for exactly one tick period after the count reaches zero

Behaviour:
- Reset (async assert, sync deassert by board-level logic):
  - state=IDLE, led=0, done_sig=0.
  - Tick counter, debouncer counter and synchroniser flops = 0; stable button = released.
- Button path:
  - go_btn is inverted, then passed through a 2-FF synchroniser.
  - Debouncer: the stable level changes only after the synchronised level differs from it for DEBOUNCE_COUNT consecutive clks. Any mismatch-free cycle clears the counter.
  - go_press = 1-clk pulse on the stable released->pressed edge.
  - Latency from the go_btn falling edge to go_press is 2+DEBOUNCE_COUNT to 3+DEBOUNCE_COUNT clks.
  - Bounces shorter than DEBOUNCE_COUNT never produce go_press.
- Tick generator:
  - Width is clog2(TICK_COUNT). It counts 0..TICK_COUNT-1 and wraps.
  - tick=1 while count==TICK_COUNT-1.
  - Cleared to 0 on the clk that leaves IDLE, so the first tick comes exactly TICK_COUNT clks after entering COUNTING.
  - Free-runs in COUNTING and DONE; held at 0 in IDLE.
- States (2-bit encoding; fourth code unused and recovers to IDLE on the next clk):
  - IDLE:
    - done_sig=0; led holds its last value.
    - On go_press: next state COUNTING, led<=START_VALUE.
  - COUNTING:
    - On tick: if led!=0 then led<=led-1; if led==0 then next state DONE.
    - The zero value is therefore displayed for one full tick period.
  - DONE:
    - done_sig=1 (Moore output, decoded from state and registered so it is glitch-free).
    - On tick: next state IDLE, led held at 0.
- Boundary conditions:
  - go_press during COUNTING or DONE is ignored. It does not restart or extend the count.
  - A button held through DONE->IDLE does not retrigger; only a new edge does.
  - START_VALUE=0 gives COUNTING for one tick, then DONE.
  - led never wraps below 0.
  - rst mid-count returns all outputs to reset values immediately (asynchronous).
  - A press pending in the debouncer at reset is discarded.
- Total count duration from go_press: (START_VALUE+1)*TICK_COUNT clks in COUNTING, plus TICK_COUNT clks in DONE.

Decomposition:
- Shared package/header holds the state localparams: STATE_IDLE=2'd0, STATE_COUNTING=2'd1, STATE_DONE=2'd2. The up-counter FSM uses the same values.
- One sub-module, button_debounce (parameter DEBOUNCE_COUNT), containing:
  - ports clk, rst, btn_n_in;
  - the synchroniser and stable-level register;
  - outputs pressed_level and press_pulse.
- Tick generator and FSM stay in fsm_countdown.

Test Plan:
All scenarios use TICK_COUNT=4, DEBOUNCE_COUNT=3, START_VALUE=4'h3.
1. Reset: assert rst mid-cycle -> led=0, done_sig=0 immediately; stay that way after release with go_btn=1.
2. Clean press: go_btn low for 10 clks -> go_press within 5-6 clks; led=3 one clk later, then 2, 1, 0 at 4-clk intervals. 4 clks after led reaches 0, done_sig=1 for exactly 4 clks, then IDLE with led=0.
3. Bounce rejection: go_btn pulses low 2 clks, high 1, low 2, repeated 3 times, then high -> no go_press, state stays IDLE, led unchanged.
4. Press during count: second clean press while led=2 -> sequence identical to scenario 2, no reload to 3.
5. Held button: go_btn held low through the whole count and DONE -> single count only; release then re-press -> a new count starts with led=3.
6. Reset mid-count: rst asserted while led=1 -> led=0 and done_sig=0 at once. After release, IDLE until a new press; first tick arrives 4 clks after the COUNTING entry.

Source files
------------

// File: rtl/fsm_countdown_pkg.sv
// Shared state encoding for the board's LED counter FSMs (up and down variants
// use the same codes) plus a saturating-decrement helper.
package fsm_countdown_pkg;

  localparam logic [1:0] STATE_IDLE     = 2'd0;
  localparam logic [1:0] STATE_COUNTING = 2'd1;
  localparam logic [1:0] STATE_DONE     = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = STATE_IDLE,
    S_COUNTING = STATE_COUNTING,
    S_DONE     = STATE_DONE,
    S_UNUSED   = 2'd3
  } state_t;

  function automatic logic [3:0] dec_sat(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

endpackage

// File: rtl/fsm_countdown_button_debounce.sv
// Active-low button conditioner: inversion, 2-FF synchroniser, counter-based
// debouncer and a one-clk pulse on the stable released->pressed edge.
module button_debounce #(
  parameter int DEBOUNCE_COUNT = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_in,
  output logic pressed_level,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_COUNT + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          settle;

  assign settle = (cnt == CW'(DEBOUNCE_COUNT - 1));

  // The stable level flips on the DEBOUNCE_COUNT-th consecutive mismatching clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      cnt           <= '0;
      pressed_level <= 1'b0;
      press_pulse   <= 1'b0;
    end else begin
      sync1       <= ~btn_n_in;
      sync2       <= sync1;
      press_pulse <= 1'b0;
      if (sync2 != pressed_level) begin
        if (settle) begin
          pressed_level <= sync2;
          press_pulse   <= sync2;
          cnt           <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/fsm_countdown.sv
// Moore FSM that counts the LED bank down from START_VALUE to zero after a
// debounced go press, shows done_sig for one tick period, then idles.
module fsm_countdown
  import fsm_countdown_pkg::*;
#(
  parameter int         TICK_COUNT     = 1500000,
  parameter int         DEBOUNCE_COUNT = 120000,
  parameter logic [3:0] START_VALUE    = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_btn,
  output logic [3:0] led,
  output logic       done_sig
);

  localparam int TW = $clog2(TICK_COUNT);

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          press_pulse;
  logic          pressed_level;
  logic          go_press;

  button_debounce #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .btn_n_in     (go_btn),
    .pressed_level(pressed_level),
    .press_pulse  (press_pulse)
  );

  // Qualify with the level so only a pulse on an accepted press starts a count.
  assign go_press = press_pulse & pressed_level;
  assign tick     = (tick_cnt == TW'(TICK_COUNT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      led      <= 4'd0;
      done_sig <= 1'b0;
      tick_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tick_cnt <= '0;
          done_sig <= 1'b0;
          if (go_press) begin
            state <= S_COUNTING;
            led   <= START_VALUE;
          end
        end
        S_COUNTING: begin
          tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
          if (tick) begin
            if (led != 4'd0) begin
              led <= dec_sat(led);
            end else begin
              state    <= S_DONE;
              done_sig <= 1'b1;
            end
          end
        end
        S_DONE: begin
          tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
          if (tick) begin
            state    <= S_IDLE;
            done_sig <= 1'b0;
            led      <= 4'd0;
          end
        end
        default: begin
          state    <= S_IDLE;
          done_sig <= 1'b0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule
